// File: rtl/multdiv_ctrl_pkg.sv
// Shared processor constants for the multiply/divide sequencing logic.
// Opcodes, rstatus exception codes and controller state encodings.
package multdiv_ctrl_pkg;

    localparam logic [4:0]  OPC_ALU      = 5'b00000;
    localparam logic [4:0]  ALUOP_MULT   = 5'b00110;
    localparam logic [4:0]  ALUOP_DIV    = 5'b00111;

    localparam logic [4:0]  RSTATUS_REG  = 5'd30;
    localparam logic [31:0] RSTATUS_MULT = 32'd4;
    localparam logic [31:0] RSTATUS_DIV  = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_multdiv(input logic [4:0] opcode, input logic [4:0] aluop);
        return (opcode == OPC_ALU) && ((aluop == ALUOP_MULT) || (aluop == ALUOP_DIV));
    endfunction

endpackage

// File: rtl/multdiv_ctrl_timer.sv
// BUSY-cycle counter: counts up from 0 while enabled, saturating at TIMEOUT-1.
// tc flags the last permitted BUSY cycle.
module multdiv_timer #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequences a multi-cycle multiply/divide unit from the DX stage: start pulse,
// pipeline stall, timeout abort and the single-cycle register write-back.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no operation in flight; a multdiv at DX starts one
//   BUSY    | unit running; wait for result, flush or timeout
//   DONE    | one-cycle write-back of result or rstatus exception code
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  dx_opcode,
    input  logic [4:0]  dx_aluop,
    input  logic [4:0]  dx_rd,
    input  logic        flush,
    input  logic        unit_result_rdy,
    input  logic        unit_exception,
    input  logic [31:0] unit_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        mult_operation,
    output logic        multdiv_at_dx,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    state_t      state;
    logic        op_div;
    logic [4:0]  rd_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic        tc;
    logic        detect;
    logic        dx_div;

    assign detect         = is_multdiv(dx_opcode, dx_aluop);
    assign dx_div         = (dx_aluop == ALUOP_DIV);
    assign multdiv_at_dx  = detect && (state == ST_IDLE);
    assign mult_operation = ((state == ST_IDLE) && detect && !flush) || (state == ST_BUSY);

    multdiv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state != ST_BUSY),
        .enable (state == ST_BUSY),
        .tc     (tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_div    <= 1'b0;
            rd_q      <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
        end else begin
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (detect && !flush) begin
                        state     <= ST_BUSY;
                        op_div    <= dx_div;
                        rd_q      <= dx_rd;
                        ctrl_mult <= !dx_div;
                        ctrl_div  <= dx_div;
                    end
                end
                ST_BUSY: begin
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (unit_result_rdy) begin
                        state    <= ST_DONE;
                        result_q <= unit_result;
                        exc_q    <= unit_exception;
                    end else if (tc) begin
                        state    <= ST_DONE;
                        result_q <= '0;
                        exc_q    <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wb_we   = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        if (state == ST_DONE) begin
            if (exc_q) begin
                wb_we   = 1'b1;
                wb_rd   = RSTATUS_REG;
                wb_data = op_div ? RSTATUS_DIV : RSTATUS_MULT;
            end else if (rd_q != '0) begin
                wb_we   = 1'b1;
                wb_rd   = rd_q;
                wb_data = result_q;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomized scoreboard bench for multdiv_ctrl against a transaction-level model
// of outcome (result, exception, timeout, flush, reset) and stall length.
module tb_multdiv_ctrl;

    localparam int TO = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  dx_opcode, dx_aluop, dx_rd;
    logic        flush, unit_result_rdy, unit_exception;
    logic [31:0] unit_result;
    logic        ctrl_mult, ctrl_div, mult_operation, multdiv_at_dx, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    multdiv_ctrl #(.TIMEOUT(TO)) dut (
        .clock           (clock),
        .reset           (reset),
        .dx_opcode       (dx_opcode),
        .dx_aluop        (dx_aluop),
        .dx_rd           (dx_rd),
        .flush           (flush),
        .unit_result_rdy (unit_result_rdy),
        .unit_exception  (unit_exception),
        .unit_result     (unit_result),
        .ctrl_mult       (ctrl_mult),
        .ctrl_div        (ctrl_div),
        .mult_operation  (mult_operation),
        .multdiv_at_dx   (multdiv_at_dx),
        .wb_we           (wb_we),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  n_mult_pulse = 0;
    int  n_div_pulse = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write-back the DUT presents is matched against the scoreboard.
    always @(negedge clock) begin
        chk("pulse_exclusive", {31'd0, ctrl_mult & ctrl_div}, 32'd0);
        n_mult_pulse += int'(ctrl_mult);
        n_div_pulse  += int'(ctrl_div);
        if (wb_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write at %0t",
                         wb_rd, wb_data, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
            end
        end else begin
            chk("wb_rd_quiet", {27'd0, wb_rd}, 32'd0);
            chk("wb_data_quiet", wb_data, 32'd0);
        end
    end

    // lat: BUSY cycle (1-based) in which the unit reports ready, 0 = never.
    // flush_at / reset_at: BUSY cycle in which that abort is applied, 0 = none.
    task automatic run_op(input bit is_div, input logic [4:0] rd, input int lat, input bit exc,
                          input logic [31:0] data, input int flush_at, input int reset_at,
                          input bit done_noise);
        int  stop, stop_c, abort_at, mop, m0, d0;
        bit  rdy_hit, completes, exp_we;
        wr_t w;

        rdy_hit  = (lat > 0) && (lat <= TO);
        stop_c   = rdy_hit ? lat : TO;
        abort_at = (flush_at > 0) ? flush_at : reset_at;
        if ((abort_at > 0) && (abort_at <= stop_c)) begin
            completes = 1'b0;
            stop      = abort_at;
        end else begin
            completes = 1'b1;
            stop      = stop_c;
        end
        exp_we = 1'b0;
        if (completes) begin
            if (!rdy_hit || exc) begin
                w.rd   = 5'd30;
                w.data = is_div ? 32'd5 : 32'd4;
                exp_q.push_back(w);
                exp_we = 1'b1;
            end else if (rd != 5'd0) begin
                w.rd   = rd;
                w.data = data;
                exp_q.push_back(w);
                exp_we = 1'b1;
            end
        end

        m0  = n_mult_pulse;
        d0  = n_div_pulse;
        mop = 0;

        @(posedge clock); #1;
        dx_opcode = 5'b00000;
        dx_aluop  = is_div ? 5'b00111 : 5'b00110;
        dx_rd     = rd;
        @(negedge clock);
        chk("at_dx_idle", {31'd0, multdiv_at_dx}, 32'd1);
        mop += int'(mult_operation);

        for (int n = 1; n <= stop; n++) begin
            @(posedge clock); #1;
            unit_result_rdy = (n == lat);
            unit_exception  = (n == lat) ? exc : 1'($urandom);
            unit_result     = (n == lat) ? data : $urandom;
            flush           = (n == flush_at);
            reset           = (n == reset_at);
            @(negedge clock);
            if (n == 1) chk("at_dx_busy", {31'd0, multdiv_at_dx}, 32'd0);
            mop += int'(mult_operation);
        end

        if (completes) begin
            @(posedge clock); #1;
            unit_result_rdy = done_noise;
            flush           = done_noise;
            unit_exception  = 1'($urandom);
            unit_result     = $urandom;
            @(negedge clock);
            chk("done_we", {31'd0, wb_we}, {31'd0, exp_we});
            chk("done_stall", {31'd0, mult_operation}, 32'd0);
            chk("done_at_dx", {31'd0, multdiv_at_dx}, 32'd0);
        end

        // Following IDLE cycle: DX squashed/advanced; a late ready must be ignored.
        @(posedge clock); #1;
        dx_opcode       = 5'b00001;
        dx_aluop        = 5'($urandom);
        unit_result_rdy = !completes;
        unit_exception  = 1'($urandom);
        flush           = 1'b0;
        reset           = 1'b0;
        @(negedge clock);
        chk("idle_we", {31'd0, wb_we}, 32'd0);
        chk("idle_stall", {31'd0, mult_operation}, 32'd0);
        chk("stall_cycles", mop, 1 + stop);
        chk("mult_pulses", n_mult_pulse - m0, {31'd0, !is_div});
        chk("div_pulses", n_div_pulse - d0, {31'd0, is_div});

        @(posedge clock); #1;
        unit_result_rdy = 1'b0;
        @(negedge clock);
        chk("after_we", {31'd0, wb_we}, 32'd0);
    endtask

    initial begin
        logic [9:0] nd [4];
        reset = 1'b1;
        dx_opcode = '0; dx_aluop = '0; dx_rd = '0;
        flush = 1'b0; unit_result_rdy = 1'b0; unit_exception = 1'b0; unit_result = '0;

        repeat (3) @(negedge clock);
        chk("rst_stall", {31'd0, mult_operation}, 32'd0);
        chk("rst_at_dx", {31'd0, multdiv_at_dx}, 32'd0);
        chk("rst_pulses", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Non-multdiv encodings must never start or stall.
        nd[0] = {5'b00000, 5'b00101};
        nd[1] = {5'b00001, 5'b00110};
        nd[2] = {5'b00010, 5'b00111};
        nd[3] = {5'b00000, 5'b01000};
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            dx_opcode = nd[i][9:5];
            dx_aluop  = nd[i][4:0];
            dx_rd     = 5'd3;
            @(negedge clock);
            chk("nd_at_dx", {31'd0, multdiv_at_dx}, 32'd0);
            chk("nd_stall", {31'd0, mult_operation}, 32'd0);
            @(negedge clock);
            chk("nd_pulse", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
        end

        run_op(1'b0, 5'd5,  8,  1'b0, 32'h0000_0042, 0, 0, 1'b0);
        run_op(1'b1, 5'd7,  3,  1'b1, 32'h1234_5678, 0, 0, 1'b0);
        run_op(1'b0, 5'd9,  0,  1'b0, 32'h0,         0, 0, 1'b0);
        run_op(1'b0, 5'd0,  4,  1'b0, 32'h0000_1234, 0, 0, 1'b0);
        run_op(1'b0, 5'd12, 6,  1'b0, 32'hDEAD_BEEF, 3, 0, 1'b0);
        run_op(1'b1, 5'd12, 6,  1'b0, 32'hDEAD_BEEF, 0, 3, 1'b0);
        run_op(1'b0, 5'd3,  TO, 1'b0, 32'h0000_CAFE, 0, 0, 1'b0);
        run_op(1'b1, 5'd3,  TO + 1, 1'b0, 32'h0000_CAFE, 0, 0, 1'b0);
        run_op(1'b0, 5'd6,  2,  1'b0, 32'h0BAD_F00D, 0, 0, 1'b1);

        for (int t = 0; t < 60; t++) begin
            int r, s, lat, fa, ra;
            logic [4:0] rd;
            r   = $urandom_range(0, 9);
            lat = (r < 2) ? 0 : ((r < 4) ? $urandom_range(35, 45) : $urandom_range(1, 12));
            s   = $urandom_range(0, 9);
            fa  = (s == 0) ? $urandom_range(1, 8) : 0;
            ra  = (s == 1) ? $urandom_range(1, 8) : 0;
            rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            run_op(1'($urandom), rd, lat, ($urandom_range(0, 3) == 0), $urandom, fa, ra,
                   1'($urandom));
        end

        repeat (2) @(negedge clock);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40, meaning max BUSY cycles before the operation is aborted with an exception.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dx_opcode  input  5  opcode of the instruction in DX.
REQ-005 dx_aluop  input  5  ALU op field of the DX instruction.
REQ-006 dx_rd  input  5  destination register of the DX instruction.
REQ-007 flush  input  1  squash in-flight DX/multdiv work (taken branch/jump).
REQ-008 unit_result_rdy  input  1  multdiv unit result valid.
REQ-009 unit_exception  input  1  multdiv unit overflow/divide-by-zero, valid with unit_result_rdy.
REQ-010 unit_result  input  32  multdiv unit result.
REQ-011 ctrl_mult  output  1  one-cycle start pulse to the unit, multiply.
REQ-012 ctrl_div  output  1  one-cycle start pulse to the unit, divide.
REQ-013 mult_operation  output  1  pipeline stall request to the stall unit.
REQ-014 multdiv_at_dx  output  1  DX holds a multdiv instruction not yet accepted.
REQ-015 wb_we  output  1  register-file write enable for the multdiv result.
REQ-016 wb_rd  output  5  write-back destination.
REQ-017 wb_data  output  32  write-back data.

Function
REQ-018 Multdiv detect: dx_opcode==00000 and dx_aluop==00110 (mult) or 00111 (div); multdiv_at_dx = detect and state==IDLE, combinational.
REQ-019 States IDLE, BUSY, DONE; detect in IDLE without flush -> BUSY next edge, latching op type and dx_rd.
REQ-020 ctrl_mult/ctrl_div high exactly one cycle, first BUSY cycle, per latched op; never both.
REQ-021 mult_operation = (IDLE and detect and not flush) or BUSY; low in DONE and otherwise.
REQ-022 BUSY cycle counter starts at 0 on BUSY entry, increments each BUSY cycle, saturating at TIMEOUT-1.
REQ-023 BUSY and unit_result_rdy -> DONE, capturing unit_result and unit_exception.
REQ-024 BUSY, counter==TIMEOUT-1, no unit_result_rdy -> DONE with exception set and data 0; rdy in the same cycle wins over timeout.
REQ-025 DONE lasts exactly one cycle, then IDLE; detect in DONE is ignored (same stalled instruction).
REQ-026 In DONE without exception: wb_we = (latched rd != 0), wb_rd = latched rd, wb_data = captured result.
REQ-027 In DONE with exception: wb_we=1, wb_rd=30, wb_data=4 for mult, 5 for div.
REQ-028 wb_we low in all states other than DONE; wb_rd/wb_data 0 when wb_we low.
REQ-029 flush in BUSY -> IDLE next edge, no write-back, late unit_result_rdy ignored; flush in DONE does not suppress write-back.
REQ-030 unit_result_rdy in IDLE or DONE is ignored.

Reset
REQ-031 reset forces IDLE, counter 0, latched rd/op/result/exception 0 on the next edge, overriding all other inputs.
REQ-032 During and after reset, all outputs 0 until a detect occurs; reset mid-BUSY discards the operation with no write-back or start pulse.

Structure
REQ-033 Opcode/aluop constants, rstatus codes (30, 4, 5) and state encodings in the shared processor constants package.
REQ-034 Cycle counter as sub-module multdiv_timer (clear, enable, terminal-count output, TIMEOUT parameter).

Verification
REQ-035 mult at DX in IDLE, rd=5, rdy after 8 cycles with 0x00000042 -> ctrl_mult pulse 1 cycle, mult_operation high 9 cycles, then wb_we=1, rd=5, data=0x42.
REQ-036 div, rdy with unit_exception=1 -> wb_we=1, wb_rd=30, wb_data=5.
REQ-037 mult, unit never ready, TIMEOUT=40 -> DONE after 40 BUSY cycles, wb_rd=30, wb_data=4, mult_operation drops.
REQ-038 mult rd=0, valid result -> no register write, returns to IDLE.
REQ-039 flush at BUSY cycle 3, then rdy -> no write-back, state IDLE; reset mid-BUSY -> same.
REQ-040 rdy coincident with counter==TIMEOUT-1 -> unit result written, no exception.
